// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : servo_pkg
// Description : Shared constants and helpers for the multi-channel servo PWM
//               generator: default frame timing, slew-feature switch and the
//               position-to-pulse-width mapping.
//               Optional feature macro: SERVO_SLEW_EN (slew-limited updates).
// Revision    : 1.0 - initial release
// ============================================================================
package servo_pkg;

  // Default timing: 20 ms frame, 0.5 ms minimum pulse at 50 MHz.
  localparam int unsigned PERIOD_DEF    = 1_000_000;
  localparam int unsigned PULSE_MIN_DEF = 25_000;
  localparam int unsigned SCALE_DEF     = 392;
  localparam int unsigned WW            = $clog2(PERIOD_DEF);

  // Compile-time switch for the slew limiter; a constant keeps both builds
  // structurally identical and lets synthesis strip the unused path.
`ifdef SERVO_SLEW_EN
  localparam bit SLEW_ON = 1'b1;
`else
  localparam bit SLEW_ON = 1'b0;
`endif

  // Unsigned full-width mapping of a position code to a pulse width in cycles.
  function automatic logic [31:0] pos2width(input logic [31:0] pos,
                                            input logic [31:0] pulse_min,
                                            input logic [31:0] scale);
    return pulse_min + pos * scale;
  endfunction

endpackage
`default_nettype wire

// File: rtl/servo_pwm_ch.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_ch
// Description : One servo channel. Holds the target and current pulse widths,
//               applies the frame-boundary update (optionally slew limited),
//               and drives the registered pulse and settled flags.
//               Optional feature macro: SERVO_SLEW_EN (via servo_pkg::SLEW_ON).
// Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_ch
  import servo_pkg::*;
#(
  parameter int            CW      = 20,
  parameter logic [CW-1:0] RESET_W = '0,
  parameter int            SLEW    = 2_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] cnt,
  input  logic          update,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_width,
  output logic          pwm,
  output logic          settled
);

  localparam logic signed [CW:0] C_SLEW = (CW+1)'(SLEW);

  logic [CW-1:0]        r_tgt;
  logic [CW-1:0]        r_cur;
  logic signed [CW:0]   w_diff;
  logic [CW-1:0]        w_next;

  // Next current width: jump to target, or step by SLEW when the gap is larger.
  always_comb begin
    w_diff = $signed({1'b0, r_tgt}) - $signed({1'b0, r_cur});
    w_next = r_tgt;
    if (SLEW_ON) begin
      if (w_diff > C_SLEW) begin
        w_next = r_cur + CW'(SLEW);
      end else if (w_diff < -C_SLEW) begin
        w_next = r_cur - CW'(SLEW);
      end
    end
  end

  // Target register: last accepted write in a frame wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tgt <= RESET_W;
    end else if (wr_en) begin
      r_tgt <= wr_width;
    end
  end

  // Current width only changes at the frame boundary, so pulses never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur <= RESET_W;
    end else if (update) begin
      r_cur <= w_next;
    end
  end

  // Registered outputs: width W yields exactly W high cycles per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm     <= 1'b0;
      settled <= 1'b1;
    end else begin
      pwm     <= (cnt < r_cur);
      settled <= (r_cur == r_tgt);
    end
  end

endmodule
`default_nettype wire

// File: rtl/servo_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_multi
// Description : Multi-channel hobby-servo PWM generator. Shared frame counter,
//               valid/ready position command port with out-of-range error
//               pulse, frame tick, and N_CH servo_pwm_ch instances.
//               Optional feature macro: SERVO_SLEW_EN (slew-limited updates).
// Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int POS_W     = 8,
  parameter int PERIOD    = PERIOD_DEF,
  parameter int PULSE_MIN = PULSE_MIN_DEF,
  parameter int SCALE     = SCALE_DEF,
  parameter int RESET_POS = 128,
  parameter int SLEW      = 2_000,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CH_W-1:0]  cmd_ch,
  input  logic [POS_W-1:0] cmd_pos,
  output logic             cmd_err,
  output logic [N_CH-1:0]  pwm_out,
  output logic             frame_tick,
  output logic [N_CH-1:0]  settled
);

  localparam int           CW        = $clog2(PERIOD);
  localparam logic [CW-1:0] C_LAST   = CW'(PERIOD - 1);
  localparam logic [CW-1:0] C_RESET_W = CW'(pos2width(32'(RESET_POS), PULSE_MIN, SCALE));

  logic [CW-1:0]   r_cnt;
  logic            w_update;
  logic            w_accept;
  logic            w_ch_ok;
  logic [CW-1:0]   w_width;
  logic [N_CH-1:0] w_wr_en;

  // The update cycle is the last count of the frame; commands stall there.
  assign w_update  = (r_cnt == C_LAST);
  assign cmd_ready = ~rst & ~w_update;
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_ch_ok   = ({{(32-CH_W){1'b0}}, cmd_ch} < 32'(N_CH));
  assign w_width   = CW'(pos2width(32'(cmd_pos), PULSE_MIN, SCALE));

  // Frame counter 0..PERIOD-1; reset release always starts a fresh frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_update) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Frame-start tick and error pulse for accepted out-of-range commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_tick <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      frame_tick <= (r_cnt == '0);
      cmd_err    <= w_accept & ~w_ch_ok;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign w_wr_en[i] = w_accept & w_ch_ok & (cmd_ch == CH_W'(i));

    servo_pwm_ch #(
      .CW      (CW),
      .RESET_W (C_RESET_W),
      .SLEW    (SLEW)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .cnt      (r_cnt),
      .update   (w_update),
      .wr_en    (w_wr_en[i]),
      .wr_width (w_width),
      .pwm      (pwm_out[i]),
      .settled  (settled[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_servo_pwm_multi
// Description : Directed self-checking bench for servo_pwm_multi. A four
//               channel instance exercises pulse widths, frame timing and the
//               command handshake; a five channel instance exercises the
//               out-of-range channel error (index 5 needs a 3-bit port).
//               Optional feature macro: SERVO_SLEW_EN (selects expectations).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_multi;

`ifdef SERVO_SLEW_EN
  localparam bit SLEW_B = 1'b1;
`else
  localparam bit SLEW_B = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_ch = '0;
  logic [7:0] cmd_pos = '0;
  logic       cmd_ready, cmd_err, frame_tick;
  logic [3:0] pwm_out, settled;

  logic       c5_valid = 1'b0;
  logic [2:0] c5_ch = '0;
  logic [7:0] c5_pos = '0;
  logic       c5_ready, c5_err, c5_tick;
  logic [4:0] c5_pwm, c5_settled;

  int checks   = 0;
  int failures = 0;

  int acc[4];
  int last_w[4];
  int gap = 0;
  int last_gap = 0;

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .N_CH(4), .POS_W(8), .PERIOD(1000), .PULSE_MIN(50), .SCALE(2),
    .RESET_POS(128), .SLEW(100)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_pos(cmd_pos), .cmd_err(cmd_err),
    .pwm_out(pwm_out), .frame_tick(frame_tick), .settled(settled)
  );

  servo_pwm_multi #(
    .N_CH(5), .POS_W(8), .PERIOD(1000), .PULSE_MIN(50), .SCALE(2),
    .RESET_POS(128), .SLEW(100)
  ) dut5 (
    .clk(clk), .rst(rst), .cmd_valid(c5_valid), .cmd_ready(c5_ready),
    .cmd_ch(c5_ch), .cmd_pos(c5_pos), .cmd_err(c5_err),
    .pwm_out(c5_pwm), .frame_tick(c5_tick), .settled(c5_settled)
  );

  // Per-frame high-cycle counter and tick spacing, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) acc[i] <= 0;
      gap <= 0;
    end else if (frame_tick) begin
      for (int i = 0; i < 4; i++) begin
        last_w[i] <= acc[i];
        acc[i]    <= int'(pwm_out[i]);
      end
      last_gap <= gap;
      gap      <= 1;
    end else begin
      for (int i = 0; i < 4; i++) acc[i] <= acc[i] + int'(pwm_out[i]);
      gap <= gap + 1;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance to the next frame tick (bounded), then settle past the monitor.
  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (frame_tick !== 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk(tag, int'(n < 1100), 1);
  endtask

  initial begin
    // ---------------- reset state ----------------
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_tick", int'(frame_tick), 0);
    chk("rst_err", int'(cmd_err), 0);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_settled", int'(settled), 15);
    chk("rst_pwm5", int'(c5_pwm), 0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- out-of-range channel on the 5-channel instance ----------
    repeat (5) @(negedge clk);
    c5_valid = 1'b1; c5_ch = 3'd5; c5_pos = 8'd0;
    #1 chk("err_ready", int'(c5_ready), 1);
    @(negedge clk);
    c5_valid = 1'b0;
    #1 chk("err_pulse", int'(c5_err), 1);
    @(negedge clk);
    #1 chk("err_once", int'(c5_err), 0);
    @(negedge clk);
    #1 chk("err_no_change", int'(c5_settled), 31);
    chk("err_tick5", int'(c5_tick), 0);

    // ---------------- first full frame after reset ----------------
    wait_tick("t1_tick");
    for (int i = 0; i < 4; i++) chk($sformatf("t1_w%0d", i), last_w[i], 306);
    chk("t1_gap", last_gap, 1000);
    chk("t1_settled", int'(settled), 15);
    chk("t1_err", int'(cmd_err), 0);

    // ---------------- ch2 -> 255 mid-frame ----------------
    repeat (100) @(negedge clk);
    cmd_valid = 1'b1; cmd_ch = 2'd2; cmd_pos = 8'd255;
    #1 chk("t2_ready", int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("t2_settled_pend", int'(settled), 4'b1011);
    chk("t2_err", int'(cmd_err), 0);
    wait_tick("t2_tick0");
    chk("t2_cur_frame", last_w[2], 306);
    wait_tick("t2_tick1");
    chk("t2_f1_ch2", last_w[2], SLEW_B ? 406 : 560);
    chk("t2_f1_ch3", last_w[3], 306);
    chk("t2_f1_ch0", last_w[0], 306);
    wait_tick("t2_tick2");
    chk("t2_f2_ch2", last_w[2], SLEW_B ? 506 : 560);
    wait_tick("t2_tick3");
    chk("t2_f3_ch2", last_w[2], 560);
    chk("t2_settled", int'(settled), 15);

    // ---------------- command presented in the update cycle ----------------
    repeat (998) @(negedge clk);
    cmd_valid = 1'b1; cmd_ch = 2'd1; cmd_pos = 8'd0;
    #1 chk("t3_stall", int'(cmd_ready), 0);
    @(negedge clk);
    #1 chk("t3_ready_cnt0", int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1 chk("t3_tick", int'(frame_tick), 1);
    @(negedge clk);
    #1 chk("t3_accepted", int'(settled), 4'b1101);
    wait_tick("t3_tick1");
    chk("t3_f1_ch1", last_w[1], 306);
    chk("t3_f1_ch2", last_w[2], 560);
    wait_tick("t3_tick2");
    chk("t3_f2_ch1", last_w[1], SLEW_B ? 206 : 50);
    wait_tick("t3_tick3");
    chk("t3_f3_ch1", last_w[1], SLEW_B ? 106 : 50);
    wait_tick("t3_tick4");
    chk("t3_f4_ch1", last_w[1], 50);

    // ---------------- ch0 128 -> 0, slew ramp ----------------
    repeat (200) @(negedge clk);
    cmd_valid = 1'b1; cmd_ch = 2'd0; cmd_pos = 8'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_tick("t5_tick0");
    chk("t5_f0_w", last_w[0], 306);
    chk("t5_f0_s", int'(settled[0]), SLEW_B ? 0 : 1);
    wait_tick("t5_tick1");
    chk("t5_f1_w", last_w[0], SLEW_B ? 206 : 50);
    chk("t5_f1_s", int'(settled[0]), SLEW_B ? 0 : 1);
    wait_tick("t5_tick2");
    chk("t5_f2_w", last_w[0], SLEW_B ? 106 : 50);
    chk("t5_f2_s", int'(settled[0]), 1);
    wait_tick("t5_tick3");
    chk("t5_f3_w", last_w[0], 50);

    // ---------------- reset mid-pulse ----------------
    repeat (100) @(negedge clk);
    #1 chk("t6_mid_pwm", int'(pwm_out), 4'b1100);
    rst = 1'b1;
    #1 chk("t6_pwm_drop", int'(pwm_out), 0);
    chk("t6_ready", int'(cmd_ready), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_tick("t6_tick0");
    wait_tick("t6_tick1");
    for (int i = 0; i < 4; i++) chk($sformatf("t6_w%0d", i), last_w[i], 306);
    chk("t6_gap", last_gap, 1000);
    chk("t6_settled", int'(settled), 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
